// File: rtl/display_pkg.sv
// Shared constants for the display framebuffer reader/writer pair: header
// op codes, flag field, size field width and the writer's state encoding.
package display_pkg;

  localparam int unsigned PIXEL_WIDTH  = 16;
  localparam int unsigned STREAM_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH   = 32;
  localparam int unsigned SIZE_W       = 28;

  localparam logic [1:0] OP_READ   = 2'h1;
  localparam logic [1:0] OP_WRITE  = 2'h2;
  localparam logic [1:0] HDR_FLAGS = 2'h3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } wr_state_e;

  function automatic logic [STREAM_WIDTH-1:0] make_header(input logic [1:0] op,
                                                          input logic [SIZE_W-1:0] size);
    return {op, HDR_FLAGS, size};
  endfunction

endpackage

// File: rtl/pixel_packer_16to32.sv
// Pairs 16-bit pixels into 32-bit words (first pixel in the low half); the
// completed word is presented combinationally in the cycle of the second pixel.
module pixel_packer_16to32
  import display_pkg::*;
(
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    pad_i,
  input  logic                    s_valid_i,
  input  logic [PIXEL_WIDTH-1:0]  s_data_i,
  output logic                    s_ready_o,
  input  logic                    out_ready_i,
  output logic                    out_valid_o,
  output logic [STREAM_WIDTH-1:0] out_data_o,
  output logic                    half_o
);

  logic                   half_q, half_d;
  logic [PIXEL_WIDTH-1:0] lo_q, lo_d;
  logic                   hs_s;

  assign s_ready_o = en_i && out_ready_i;
  assign hs_s      = s_valid_i && s_ready_o;
  assign half_o    = half_q;

  // Pair assembly; a pad request flushes a lone low pixel with a zero high half.
  always_comb begin
    half_d      = half_q;
    lo_d        = lo_q;
    out_valid_o = 1'b0;
    out_data_o  = {s_data_i, lo_q};
    if (clr_i) begin
      half_d = 1'b0;
    end else if (pad_i) begin
      out_valid_o = 1'b1;
      out_data_o  = {16'h0000, (half_q ? lo_q : 16'h0000)};
      half_d      = 1'b0;
    end else if (hs_s) begin
      if (half_q) begin
        out_valid_o = 1'b1;
        half_d      = 1'b0;
      end else begin
        lo_d   = s_data_i;
        half_d = 1'b1;
      end
    end else begin
      half_d = half_q;
    end
  end

  // Pair register.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      half_q <= 1'b0;
      lo_q   <= 16'h0000;
    end else begin
      half_q <= half_d;
      lo_q   <= lo_d;
    end
  end

endmodule

// File: rtl/display_framebuffer_writer.sv
// Packs a 16-bit pixel stream into a FrameStreamingCore write command:
// header word, base address word, then DISPLAY_SIZE_IN_BYTES/4 payload words.
module display_framebuffer_writer
  import display_pkg::*;
#(
  parameter int unsigned DISPLAY_SIZE_IN_BYTES = 320*480*2
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   fb_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    frame_error,
  input  logic                    s_pix_axis_tvalid,
  output logic                    s_pix_axis_tready,
  input  logic                    s_pix_axis_tlast,
  input  logic [PIXEL_WIDTH-1:0]  s_pix_axis_tdata,
  output logic                    m_cmd_axis_tvalid,
  input  logic                    m_cmd_axis_tready,
  output logic                    m_cmd_axis_tlast,
  output logic [STREAM_WIDTH-1:0] m_cmd_axis_tdata
);

  localparam logic [SIZE_W-1:0] SIZE_FIELD = SIZE_W'(DISPLAY_SIZE_IN_BYTES);
  localparam logic [SIZE_W-1:0] WORD_COUNT = SIZE_W'(DISPLAY_SIZE_IN_BYTES / 4);

  wr_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [SIZE_W-1:0]      wcnt_q, wcnt_d;
  logic [SIZE_W-1:0]      ld_cnt_q, ld_cnt_d;
  logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [STREAM_WIDTH-1:0] tdata_q, tdata_d;

  logic out_ready_s, m_hs_s, pix_hs_s, final_pix_s;
  logic pk_en_s, pk_pad_s, pk_clr_s, pk_valid_s, pk_half_s;
  logic [STREAM_WIDTH-1:0] pk_data_s;

  // ld_cnt tracks words still to be loaded into the output register; wcnt
  // tracks words still to be handshaken out.
  assign out_ready_s = !tvalid_q || m_cmd_axis_tready;
  assign m_hs_s      = tvalid_q && m_cmd_axis_tready;
  assign pk_en_s     = (state_q == ST_DATA) && (ld_cnt_q != 28'd0);
  assign pk_pad_s    = (state_q == ST_FLUSH) && (ld_cnt_q != 28'd0) && out_ready_s;
  assign pk_clr_s    = (state_q == ST_IDLE) && start;
  assign pix_hs_s    = s_pix_axis_tvalid && s_pix_axis_tready;
  assign final_pix_s = pk_half_s && (ld_cnt_q == 28'd1);

  pixel_packer_16to32 u_packer (
    .aclk        (aclk),
    .resetn      (resetn),
    .clr_i       (pk_clr_s),
    .en_i        (pk_en_s),
    .pad_i       (pk_pad_s),
    .s_valid_i   (s_pix_axis_tvalid),
    .s_data_i    (s_pix_axis_tdata),
    .s_ready_o   (s_pix_axis_tready),
    .out_ready_i (out_ready_s),
    .out_valid_o (pk_valid_s),
    .out_data_o  (pk_data_s),
    .half_o      (pk_half_s)
  );

  // Next-state and output-register logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wcnt_d   = wcnt_q;
    ld_cnt_d = ld_cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = fb_addr;
          tdata_d  = make_header(OP_WRITE, SIZE_FIELD);
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          wcnt_d   = WORD_COUNT;
          ld_cnt_d = WORD_COUNT;
          state_d  = ST_HDR;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_HDR: begin
        if (m_cmd_axis_tready) begin
          tdata_d = addr_q;
          state_d = ST_ADDR;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_ADDR: begin
        if (m_cmd_axis_tready) begin
          tvalid_d = 1'b0;
          state_d  = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA, ST_FLUSH: begin
        if (pk_valid_s) begin
          tdata_d  = pk_data_s;
          tvalid_d = 1'b1;
          tlast_d  = (ld_cnt_q == 28'd1);
          ld_cnt_d = ld_cnt_q - 28'd1;
        end else if (m_hs_s) begin
          tvalid_d = 1'b0;
        end else begin
          tvalid_d = tvalid_q;
        end
        if (m_hs_s) begin
          wcnt_d = wcnt_q - 28'd1;
          if (wcnt_q == 28'd1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = state_q;
          end
        end else begin
          wcnt_d = wcnt_q;
        end
        // Pixel handshakes never coincide with the final payload handshake.
        if (pix_hs_s) begin
          if (final_pix_s) begin
            err_d = err_q | !s_pix_axis_tlast;
          end else if (s_pix_axis_tlast) begin
            err_d   = 1'b1;
            state_d = ST_FLUSH;
          end else begin
            err_d = err_q;
          end
        end else begin
          err_d = err_q;
        end
      end
      ST_DONE: begin
        busy_d   = 1'b0;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'h0000_0000;
      wcnt_q   <= 28'd0;
      ld_cnt_q <= 28'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wcnt_q   <= wcnt_d;
      ld_cnt_q <= ld_cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign frame_error       = err_q;
  assign m_cmd_axis_tvalid = tvalid_q;
  assign m_cmd_axis_tlast  = tlast_q;
  assign m_cmd_axis_tdata  = tdata_q;

endmodule

// File: tb/tb_display_framebuffer_writer.sv
// Scoreboard bench for display_framebuffer_writer with a 16-byte frame
// (four payload words of two pixels each).
module tb_display_framebuffer_writer;

  localparam logic [31:0] HDR = 32'hB000_0010;

  logic        aclk, resetn, start, busy, done, frame_error;
  logic [31:0] fb_addr;
  logic        s_valid, s_ready, s_last;
  logic [15:0] s_data;
  logic        m_valid, m_ready, m_last;
  logic [31:0] m_data;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          done_seen = 0;
  logic        tready_toggle = 1'b0;
  logic        stall_pend = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;

  display_framebuffer_writer #(.DISPLAY_SIZE_IN_BYTES(16)) dut (
    .aclk              (aclk),
    .resetn            (resetn),
    .start             (start),
    .fb_addr           (fb_addr),
    .busy              (busy),
    .done              (done),
    .frame_error       (frame_error),
    .s_pix_axis_tvalid (s_valid),
    .s_pix_axis_tready (s_ready),
    .s_pix_axis_tlast  (s_last),
    .s_pix_axis_tdata  (s_data),
    .m_cmd_axis_tvalid (m_valid),
    .m_cmd_axis_tready (m_ready),
    .m_cmd_axis_tlast  (m_last),
    .m_cmd_axis_tdata  (m_data)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Sink ready: constant 1 or toggling every cycle.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (tready_toggle) m_ready = !m_ready;
      else m_ready = 1'b1;
    end
  end

  // Scoreboard: pop expected word on each handshake, check stability while stalled.
  always @(negedge aclk) begin
    word_t w;
    if (!resetn) begin
      stall_pend = 1'b0;
    end else begin
      if (done === 1'b1) done_seen++;
      if (stall_pend) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== stall_data || m_last !== stall_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                   m_valid, m_data, m_last, stall_data, stall_last);
        end
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got d=%h l=%b, none expected", m_data, m_last);
        end else begin
          w = exp_q.pop_front();
          if (m_data !== w.data || m_last !== w.last) begin
            errors++;
            $display("FAIL word: got d=%h l=%b, need d=%h l=%b", m_data, m_last, w.data, w.last);
          end
        end
      end
      stall_pend = (m_valid === 1'b1) && (m_ready !== 1'b1);
      stall_data = m_data;
      stall_last = m_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic l);
    word_t w;
    w.data = d;
    w.last = l;
    exp_q.push_back(w);
  endtask

  task automatic push_payload4(input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
    push_word(w0, 1'b0);
    push_word(w1, 1'b0);
    push_word(w2, 1'b0);
    push_word(w3, 1'b1);
  endtask

  task automatic start_frame(input logic [31:0] addr);
    start   = 1'b1;
    fb_addr = addr;
    push_word(HDR, 1'b0);
    push_word(addr, 1'b0);
    sync();
    start = 1'b0;
  endtask

  task automatic send_pixel(input logic [15:0] d, input logic l);
    int  n;
    logic got;
    n = 0;
    got = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!got && n < 200) begin
      @(negedge aclk);
      got = (s_ready === 1'b1);
      n++;
    end
    sync();
    s_valid = 1'b0;
    s_last  = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL pixel_timeout: pixel %h not accepted, need accept within 200 cycles", d);
    end
  endtask

  task automatic send_pixels(input int first, input int last_pix, input int tlast_idx);
    for (int i = first; i <= last_pix; i++) begin
      send_pixel(16'h1111 * 16'(i), (i == tlast_idx));
    end
  endtask

  // Returns at the falling edge inside the DONE cycle.
  task automatic wait_done(input int budget);
    int  n;
    logic got;
    n = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(negedge aclk);
      got = (done === 1'b1);
      n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: done=0 after %0d cycles, need done=1", budget);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({busy, done, frame_error, m_valid, m_last, s_ready} !== 6'b000000) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b err=%b tvalid=%b tlast=%b s_tready=%b, need all 0",
               tag, busy, done, frame_error, m_valid, m_last, s_ready);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start = 1'b0;
    fb_addr = 32'h0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = 16'h0;
    repeat (3) sync();
    @(negedge aclk);
    check_idle_outputs("reset_state");
    checks++;
    if (m_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_tdata: got %h, need 00000000", m_data);
    end
    sync();
    resetn = 1'b1;
    sync();
  endtask

  task automatic test_basic_frame(input logic toggle, input logic [31:0] addr, input string tag);
    int d0;
    tready_toggle = toggle;
    d0 = done_seen;
    start_frame(addr);
    push_payload4(32'h2222_1111, 32'h4444_3333, 32'h6666_5555, 32'h8888_7777);
    send_pixels(1, 8, 8);
    wait_done(400);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_in_done: got %b, need 1", tag, busy);
    end
    sync();
    @(negedge aclk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done: got busy=%b done=%b err=%b, need 0 0 0", tag, busy, done, frame_error);
    end
    checks++;
    if (exp_q.size() != 0 || done_seen - d0 != 1) begin
      errors++;
      $display("FAIL %s_completion: got pending=%0d done_pulses=%0d, need 0 and 1",
               tag, exp_q.size(), done_seen - d0);
    end
    tready_toggle = 1'b0;
    sync();
  endtask

  task automatic test_early_tlast();
    start_frame(32'h2000_0000);
    push_payload4(32'h2222_1111, 32'h4444_3333, 32'h0000_5555, 32'h0000_0000);
    send_pixels(1, 5, 5);
    wait_done(100);
    checks++;
    if (frame_error !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL early_tlast: got err=%b pending=%0d, need err=1 pending=0", frame_error, exp_q.size());
    end
    sync();
  endtask

  task automatic test_missing_tlast();
    start_frame(32'h3000_0000);
    @(negedge aclk);
    checks++;
    if (frame_error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear_on_start: got %b, need 0", frame_error);
    end
    sync();
    push_payload4(32'h2222_1111, 32'h4444_3333, 32'h6666_5555, 32'h8888_7777);
    send_pixels(1, 8, 0);
    s_valid = 1'b1;
    s_data  = 16'h9999;
    wait_done(100);
    checks++;
    if (frame_error !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_tlast: got err=%b pending=%0d, need err=1 pending=0", frame_error, exp_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      checks++;
      if (s_ready !== 1'b0) begin
        errors++;
        $display("FAIL pixel9_held: got s_tready=%b, need 0", s_ready);
      end
    end
    sync();
    s_valid = 1'b0;
    sync();
  endtask

  task automatic test_back_to_back();
    start_frame(32'h4000_0000);
    push_payload4(32'h2222_1111, 32'h4444_3333, 32'h6666_5555, 32'h8888_7777);
    send_pixels(1, 4, 0);
    start   = 1'b1;
    fb_addr = 32'hBAD0_0000;
    sync();
    start = 1'b0;
    send_pixels(5, 8, 8);
    wait_done(100);
    start   = 1'b1;
    fb_addr = 32'hBAD1_0000;
    sync();
    fb_addr = 32'h5000_0000;
    @(negedge aclk);
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: got tvalid=%b busy=%b in idle cycle, need 0 0", m_valid, busy);
    end
    push_word(HDR, 1'b0);
    push_word(32'h5000_0000, 1'b0);
    sync();
    start = 1'b0;
    push_payload4(32'h2222_1111, 32'h4444_3333, 32'h6666_5555, 32'h8888_7777);
    send_pixels(1, 8, 8);
    wait_done(100);
    checks++;
    if (frame_error !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: got err=%b pending=%0d, need 0 0", frame_error, exp_q.size());
    end
    sync();
  endtask

  task automatic test_reset_mid_frame();
    int n;
    start_frame(32'h6000_0000);
    push_word(32'h2222_1111, 1'b0);
    push_word(32'h4444_3333, 1'b0);
    send_pixels(1, 4, 0);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_words: got pending=%0d, need 0", exp_q.size());
    end
    sync();
    resetn = 1'b0;
    sync();
    @(negedge aclk);
    check_idle_outputs("reset_mid_frame");
    sync();
    resetn = 1'b1;
    sync();
    test_basic_frame(1'b0, 32'h7000_0000, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic_frame(1'b0, 32'h1000_0000, "basic");
    test_basic_frame(1'b1, 32'h1000_0000, "stall");
    test_early_tlast();
    test_missing_tlast();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
